// File: rtl/l2_mem_pg_seq.sv
// ============================================================================
// Module      : l2_mem_pg_seq
// Description : Staggered SRAM power-group sequencer (ON / RET / OFF) with
//               per-group prn acknowledge timeout supervision.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mem_pg_seq #(
  parameter int N_GROUPS  = 4,
  parameter int STAGGER_W = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_req_mode,
  input  logic [N_GROUPS-1:0]   i_req_mask,
  input  logic [STAGGER_W-1:0]  i_stagger_cycles,
  input  logic [TIMEOUT_W-1:0]  i_timeout_cycles,
  output logic [N_GROUPS-1:0]   o_ret,
  output logic [N_GROUPS-1:0]   o_pde,
  input  logic [N_GROUPS-1:0]   i_prn,
  output logic [2*N_GROUPS-1:0] o_grp_state,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int IDX_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int CNT_W = (STAGGER_W > TIMEOUT_W) ? STAGGER_W : TIMEOUT_W;

  localparam logic [1:0] c_mode_on  = 2'd0;
  localparam logic [1:0] c_mode_ret = 2'd1;
  localparam logic [1:0] c_mode_ill = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_mode;
  logic [N_GROUPS-1:0]     r_mask;
  logic [CNT_W-1:0]        r_stagger;
  logic [CNT_W-1:0]        r_timeout;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_sel;
  logic [N_GROUPS-1:0]     r_ret;
  logic [N_GROUPS-1:0]     r_pde;
  logic [2*N_GROUPS-1:0]   r_grp_state;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic [N_GROUPS-1:0]     w_pending;
  logic [IDX_W-1:0]        w_sel_nxt;
  logic                    w_prn_match;
  logic                    w_load;
  logic                    w_sel_load;
  logic                    w_cnt_clr;
  logic                    w_cnt_inc;
  logic                    w_set_err;

  // Lowest-index pending group wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_pending = '0;
    w_sel_nxt = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      w_pending[g] = r_mask[g] & (r_grp_state[2*g +: 2] != r_mode);
    end
    for (int g = N_GROUPS - 1; g >= 0; g--) begin
      if (w_pending[g]) begin
        w_sel_nxt = IDX_W'(g);
      end
    end
  end

  assign w_prn_match = (i_prn[r_sel] == (r_mode == c_mode_on));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sel_load  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_load      = 1'b1;
          w_state_nxt = (i_req_mode == c_mode_ill) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_pending == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_sel_load  = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_prn_match) begin
          if (r_stagger == '0) begin
            w_state_nxt = ST_SCAN;
          end else begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_GAP;
          end
        end else if (r_cnt == r_timeout) begin
          w_set_err   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_GAP: begin
        w_cnt_inc = 1'b1;
        if (r_cnt == r_stagger - CNT_W'(1)) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode      <= c_mode_on;
      r_mask      <= '0;
      r_stagger   <= '0;
      r_timeout   <= '0;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_ret       <= '0;
      r_pde       <= '0;
      r_grp_state <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_mode    <= i_req_mode;
        r_mask    <= i_req_mask;
        r_stagger <= CNT_W'(i_stagger_cycles);
        r_timeout <= CNT_W'(i_timeout_cycles);
        r_err     <= (i_req_mode == c_mode_ill);
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_sel_load) begin
        r_sel <= w_sel_nxt;
        for (int g = 0; g < N_GROUPS; g++) begin
          if (w_sel_nxt == IDX_W'(g)) begin
            r_ret[g]             <= (r_mode == c_mode_ret);
            r_pde[g]             <= (r_mode != c_mode_on);
            r_grp_state[2*g +: 2] <= r_mode;
          end
        end
      end
    end
  end

  assign o_req_ready = r_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_ret       = r_ret;
  assign o_pde       = r_pde;
  assign o_grp_state = r_grp_state;

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_pg_seq.sv
// ============================================================================
// Module      : tb_l2_mem_pg_seq
// Description : Directed self-checking bench for l2_mem_pg_seq with a simple
//               SRAM prn response model (programmable delay / stuck-at).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_mem_pg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_mode = 2'd0;
  logic [3:0]  req_mask = 4'h0;
  logic [7:0]  stagger = 8'd0;
  logic [15:0] timeout = 16'd0;
  logic [3:0]  ret;
  logic [3:0]  pde;
  logic [3:0]  prn = 4'hF;
  logic [7:0]  grp_state;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;

  int   dly = 0;
  logic [3:0] stuck_mask = 4'h0;
  logic [3:0] stuck_val = 4'h0;
  int   pcnt [4];

  l2_mem_pg_seq #(.N_GROUPS(4), .STAGGER_W(8), .TIMEOUT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_mode(req_mode), .i_req_mask(req_mask), .i_stagger_cycles(stagger),
    .i_timeout_cycles(timeout), .o_ret(ret), .o_pde(pde), .i_prn(prn),
    .o_grp_state(grp_state), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  // SRAM model: prn follows ~pde once the mismatch has lasted more than dly negedges.
  always @(negedge clk) begin
    if (rst) begin
      prn = 4'hF;
      for (int g = 0; g < 4; g++) pcnt[g] = 0;
    end else begin
      for (int g = 0; g < 4; g++) begin
        if (stuck_mask[g]) prn[g] = stuck_val[g];
        else if (prn[g] == ~pde[g]) pcnt[g] = 0;
        else begin
          pcnt[g] = pcnt[g] + 1;
          if (pcnt[g] > dly) begin
            prn[g] = ~pde[g];
            pcnt[g] = 0;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request; returns at cycle T+1 (one tick after the accept edge).
  task automatic do_accept(input logic [1:0] m, input logic [3:0] k,
                           input logic [7:0] s, input logic [15:0] t);
    @(negedge clk);
    req_valid = 1'b1; req_mode = m; req_mask = k; stagger = s; timeout = t;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    total++; if (ret !== 4'h0) begin bad++; $display("FAIL reset_ret got=%h exp=0", ret); end
    total++; if (pde !== 4'h0) begin bad++; $display("FAIL reset_pde got=%h exp=0", pde); end
    total++; if (grp_state !== 8'h00) begin bad++; $display("FAIL reset_grp got=%h exp=00", grp_state); end
    total++; if ({req_ready, busy, done, err} !== 4'b1000) begin bad++;
      $display("FAIL reset_flags got rdy/busy/done/err=%b exp=1000", {req_ready, busy, done, err}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_noop_on();
    do_accept(2'd0, 4'hF, 8'd0, 16'd10);
    total++; if ({busy, done, req_ready} !== 3'b100) begin bad++;
      $display("FAIL noop_t1 got busy/done/rdy=%b exp=100", {busy, done, req_ready}); end
    step(1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL noop_done_t2 got=%b exp=1", done); end
    total++; if ({ret, pde, grp_state} !== 16'h0000) begin bad++;
      $display("FAIL noop_outputs got ret=%h pde=%h grp=%h exp=0/0/00", ret, pde, grp_state); end
    step(1);
    total++; if ({req_ready, done, err} !== 3'b100) begin bad++;
      $display("FAIL noop_t3 got rdy/done/err=%b exp=100", {req_ready, done, err}); end
  endtask

  task automatic test_off_stagger();
    dly = 2;
    do_accept(2'd2, 4'b0101, 8'd3, 16'd100);
    total++; if (pde !== 4'b0000) begin bad++; $display("FAIL offs_pde_t1 got=%b exp=0000", pde); end
    step(1);
    total++; if (pde !== 4'b0001) begin bad++; $display("FAIL offs_pde_t2 got=%b exp=0001", pde); end
    step(6);
    total++; if (pde !== 4'b0001) begin bad++; $display("FAIL offs_pde_t8 got=%b exp=0001", pde); end
    step(1);
    total++; if (pde !== 4'b0101) begin bad++; $display("FAIL offs_pde_t9 got=%b exp=0101", pde); end
    step(6);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL offs_done_t15 got=%b exp=0", done); end
    step(1);
    total++; if ({done, err} !== 2'b10) begin bad++;
      $display("FAIL offs_done_t16 got done/err=%b exp=10", {done, err}); end
    total++; if (grp_state !== 8'h22 || ret !== 4'h0) begin bad++;
      $display("FAIL offs_state got grp=%h ret=%h exp=22/0", grp_state, ret); end
    step(1);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL offs_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_ret_then_off();
    logic [3:0] exp_pde [4];
    logic [3:0] exp_ret [4];
    exp_pde[0] = 4'b0001; exp_pde[1] = 4'b0011; exp_pde[2] = 4'b0111; exp_pde[3] = 4'b1111;
    exp_ret[0] = 4'b1110; exp_ret[1] = 4'b1100; exp_ret[2] = 4'b1000; exp_ret[3] = 4'b0000;
    dly = 0;
    do_accept(2'd1, 4'hF, 8'd0, 16'd100);
    for (int i = 0; i < 4; i++) begin
      step(i == 0 ? 1 : 2);
      total++; if (pde !== exp_pde[i] || ret !== exp_pde[i]) begin bad++;
        $display("FAIL ret_order%0d got ret=%b pde=%b exp=%b", i, ret, pde, exp_pde[i]); end
    end
    step(2);
    total++; if (done !== 1'b1 || grp_state !== 8'h55) begin bad++;
      $display("FAIL ret_done got done=%b grp=%h exp=1/55", done, grp_state); end
    step(1);
    do_accept(2'd2, 4'hF, 8'd0, 16'd100);
    for (int i = 0; i < 4; i++) begin
      step(i == 0 ? 1 : 2);
      total++; if (ret !== exp_ret[i] || pde !== 4'hF) begin bad++;
        $display("FAIL off_order%0d got ret=%b pde=%b exp=%b/1111", i, ret, pde, exp_ret[i]); end
    end
    step(2);
    total++; if (done !== 1'b1 || grp_state !== 8'hAA || err !== 1'b0) begin bad++;
      $display("FAIL off_done got done=%b grp=%h err=%b exp=1/aa/0", done, grp_state, err); end
  endtask

  task automatic test_timeout();
    stuck_mask = 4'b0010; stuck_val = 4'b0010;
    do_accept(2'd2, 4'b0010, 8'd0, 16'd5);
    step(6);
    total++; if ({busy, done, err} !== 3'b100) begin bad++;
      $display("FAIL tmo_t7 got busy/done/err=%b exp=100", {busy, done, err}); end
    step(1);
    total++; if ({done, err} !== 2'b11) begin bad++;
      $display("FAIL tmo_t8 got done/err=%b exp=11", {done, err}); end
    total++; if (pde !== 4'b0010 || grp_state !== 8'h08) begin bad++;
      $display("FAIL tmo_drive got pde=%b grp=%h exp=0010/08", pde, grp_state); end
    step(1);
    total++; if ({req_ready, err} !== 2'b11) begin bad++;
      $display("FAIL tmo_sticky got rdy/err=%b exp=11", {req_ready, err}); end
    do_accept(2'd0, 4'b0010, 8'd0, 16'd5);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", err); end
    step(3);
    total++; if ({done, err} !== 2'b10 || grp_state !== 8'h00) begin bad++;
      $display("FAIL tmo_recover got done/err=%b grp=%h exp=10/00", {done, err}, grp_state); end
    stuck_mask = 4'h0;
  endtask

  task automatic test_illegal_busy();
    int npulse;
    bit seen;
    npulse = 0;
    do_accept(2'd3, 4'hF, 8'd0, 16'd5);
    for (int i = 0; i < 2; i++) begin
      if (done) begin
        npulse++;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", err); end
      end
      if (i == 0) step(1);
    end
    total++; if (npulse != 1) begin bad++; $display("FAIL ill_done_pulses got=%0d exp=1", npulse); end
    total++; if ({ret, pde, grp_state} !== 16'h0000) begin bad++;
      $display("FAIL ill_outputs got ret=%h pde=%h grp=%h exp=0/0/00", ret, pde, grp_state); end
    step(1);
    dly = 5;
    do_accept(2'd2, 4'b0001, 8'd0, 16'd50);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_mode = 2'd2; req_mask = 4'hF;
      step(1);
      total++; if ({req_ready, busy} !== 2'b01) begin bad++;
        $display("FAIL busy_ready%0d got rdy/busy=%b exp=01", i, {req_ready, busy}); end
    end
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1);
      if (done) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL busy_done_timeout got=none exp=done"); end
    total++; if (grp_state !== 8'h02 || err !== 1'b0) begin bad++;
      $display("FAIL busy_grp got grp=%h err=%b exp=02/0", grp_state, err); end
  endtask

  task automatic test_reset_mid_gap();
    dly = 0;
    do_accept(2'd2, 4'b0011, 8'd10, 16'd50);
    step(2);
    total++; if (pde !== 4'b0001 || busy !== 1'b1) begin bad++;
      $display("FAIL gap_pre got pde=%b busy=%b exp=0001/1", pde, busy); end
    @(negedge clk);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    total++; if ({ret, pde, grp_state} !== 16'h0000) begin bad++;
      $display("FAIL gap_rst_out got ret=%h pde=%h grp=%h exp=0/0/00", ret, pde, grp_state); end
    total++; if ({req_ready, busy, done, err} !== 4'b1000) begin bad++;
      $display("FAIL gap_rst_flags got=%b exp=1000", {req_ready, busy, done, err}); end
    do_accept(2'd0, 4'hF, 8'd0, 16'd5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_reaccept got=%b exp=1", busy); end
    step(1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL gap_redone got=%b exp=1", done); end
  endtask

  initial begin
    test_reset();
    test_noop_on();
    test_off_stagger();
    apply_reset();
    test_ret_then_off();
    apply_reset();
    test_timeout();
    apply_reset();
    test_illegal_busy();
    apply_reset();
    test_reset_mid_gap();
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
